// File: rtl/csr_arbiter_pkg.sv
// Shared definitions for the two-master CSR bus arbiter: bus widths, FSM
// state encoding and the peripheral base addresses seen on the CSR bus.
package csr_arbiter_pkg;

  localparam int CSR_AW = 5;
  localparam int CSR_DW = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_ACK  = 2'd3
  } state_t;

  localparam logic [CSR_AW-1:0] PWM0_BASE = 5'h0c;
  localparam logic [CSR_AW-1:0] PWM1_BASE = 5'h0e;

endpackage

// File: rtl/csr_arbiter_if.sv
// Bundle of both master request ports and the shared peripheral CSR bus.
// The slave modport is the arbiter; the master modport is its environment.
interface csr_arbiter_if
  import csr_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = CSR_AW,
  parameter int DATA_WIDTH = CSR_DW
);

  logic                  m0_req;
  logic                  m0_we;
  logic [ADDR_WIDTH-1:0] m0_a;
  logic [DATA_WIDTH-1:0] m0_di;
  logic                  m0_ack;
  logic [DATA_WIDTH-1:0] m0_do;

  logic                  m1_req;
  logic                  m1_we;
  logic [ADDR_WIDTH-1:0] m1_a;
  logic [DATA_WIDTH-1:0] m1_di;
  logic                  m1_ack;
  logic [DATA_WIDTH-1:0] m1_do;

  logic [ADDR_WIDTH-1:0] csr_a;
  logic                  csr_we;
  logic [DATA_WIDTH-1:0] csr_do;
  logic [DATA_WIDTH-1:0] csr_di;

  modport slave (
    input  m0_req, m0_we, m0_a, m0_di,
    output m0_ack, m0_do,
    input  m1_req, m1_we, m1_a, m1_di,
    output m1_ack, m1_do,
    output csr_a, csr_we, csr_do,
    input  csr_di
  );

  modport master (
    output m0_req, m0_we, m0_a, m0_di,
    input  m0_ack, m0_do,
    output m1_req, m1_we, m1_a, m1_di,
    input  m1_ack, m1_do,
    input  csr_a, csr_we, csr_do,
    output csr_di
  );

endinterface

// File: rtl/csr_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: a lone requester wins outright,
// a tie goes to whichever master was not granted last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       gnt
);

  always_comb begin
    valid = |req;
    gnt   = (req == 2'b11) ? ~last : req[1];
  end

endmodule

// File: rtl/csr_arbiter.sv
// Two-master CSR bus arbiter: each granted master gets one complete
// IDLE->ADDR->DATA->ACK register access; all bus and ack outputs are registered.
module csr_arbiter
  import csr_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = CSR_AW,
  parameter int DATA_WIDTH = CSR_DW
) (
  input  logic        clk,
  input  logic        rst,
  csr_arbiter_if.slave bus
);

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] csr_a_reg, csr_a_next;
  logic [DATA_WIDTH-1:0] csr_do_reg, csr_do_next;
  logic                  csr_we_reg, csr_we_next;
  logic                  we_reg, we_next;
  logic                  gnt_reg, gnt_next;
  logic                  last_reg, last_next;
  logic [1:0]            ack_reg, ack_next;
  logic [DATA_WIDTH-1:0] do_reg  [2];
  logic [DATA_WIDTH-1:0] do_next [2];

  logic [1:0] req_vec;
  logic       arb_valid;
  logic       arb_gnt;

  assign req_vec = {bus.m1_req, bus.m0_req};

  rr_arb2 u_rr_arb2 (
    .req   (req_vec),
    .last  (last_reg),
    .valid (arb_valid),
    .gnt   (arb_gnt)
  );

  // Per-master completion: ack follows DATA, read data is captured on the DATA edge.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_master
      assign ack_next[gi] = (state_reg == ST_DATA) && (gnt_reg == 1'(gi));
      assign do_next[gi]  = ((state_reg == ST_DATA) && !we_reg && (gnt_reg == 1'(gi)))
                            ? bus.csr_di : do_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      csr_a_reg  <= '0;
      csr_do_reg <= '0;
      csr_we_reg <= 1'b0;
      we_reg     <= 1'b0;
      gnt_reg    <= 1'b0;
      last_reg   <= 1'b1;
      ack_reg    <= 2'b00;
      do_reg[0]  <= '0;
      do_reg[1]  <= '0;
    end else begin
      state_reg  <= state_next;
      csr_a_reg  <= csr_a_next;
      csr_do_reg <= csr_do_next;
      csr_we_reg <= csr_we_next;
      we_reg     <= we_next;
      gnt_reg    <= gnt_next;
      last_reg   <= last_next;
      ack_reg    <= ack_next;
      do_reg[0]  <= do_next[0];
      do_reg[1]  <= do_next[1];
    end
  end

  always_comb begin
    state_next  = state_reg;
    csr_a_next  = csr_a_reg;
    csr_do_next = csr_do_reg;
    csr_we_next = 1'b0;
    we_next     = we_reg;
    gnt_next    = gnt_reg;
    last_next   = last_reg;
    case (state_reg)
      ST_IDLE: begin
        if (arb_valid) begin
          gnt_next   = arb_gnt;
          last_next  = arb_gnt;
          state_next = ST_ADDR;
          if (arb_gnt) begin
            csr_a_next  = bus.m1_a;
            csr_do_next = bus.m1_di;
            we_next     = bus.m1_we;
          end else begin
            csr_a_next  = bus.m0_a;
            csr_do_next = bus.m0_di;
            we_next     = bus.m0_we;
          end
          // Strobe is registered so it is high for exactly the ADDR cycle.
          csr_we_next = we_next;
        end
      end
      ST_ADDR: state_next = ST_DATA;
      ST_DATA: state_next = ST_ACK;
      ST_ACK:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.csr_a  = csr_a_reg;
  assign bus.csr_we = csr_we_reg;
  assign bus.csr_do = csr_do_reg;
  assign bus.m0_ack = ack_reg[0];
  assign bus.m1_ack = ack_reg[1];
  assign bus.m0_do  = do_reg[0];
  assign bus.m1_do  = do_reg[1];

endmodule
